// File: rtl/lsu_pkg.sv
// ============================================================================
//  Module   : lsu_pkg
//  Summary  : Shared types, access-size codes and the alignment check for the LSU.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_X = 2'd3;

    // True when the access can never reach memory: illegal size or misaligned.
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] off);
        return (size == SIZE_X) ||
               ((size == SIZE_H) && off[0]) ||
               ((size == SIZE_W) && (off != 2'b00));
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
//  Module   : lsu_align
//  Summary  : Store byte-lane mask/replication and load shift/extension.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;
    logic        sign_b;
    logic        sign_h;

    assign shifted = rdata_i >> {off_i, 3'b000};
    assign sign_b  = ~unsigned_i & shifted[7];
    assign sign_h  = ~unsigned_i & shifted[15];

    always_comb begin
        wmask_o = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (size_i)
            SIZE_B: begin
                wmask_o = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sign_b}}, shifted[7:0]};
            end
            SIZE_H: begin
                wmask_o = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sign_h}}, shifted[15:0]};
            end
            default: begin
                wmask_o = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_initiator.sv
// ============================================================================
//  Module   : lsu_mem_initiator
//  Summary  : Single-outstanding load/store initiator toward a word-addressed data memory.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              wen_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              req_ready_q;
    logic              mem_req_valid_q;
    logic              rsp_valid_q;

    logic [3:0]        w_mask;
    logic [31:0]       w_wdata;
    logic [31:0]       w_load;

    lsu_align u_align (
        .size_i     (size_q),
        .off_i      (addr_q[1:0]),
        .unsigned_i (unsigned_q),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_rdata),
        .wmask_o    (w_mask),
        .wdata_o    (w_wdata),
        .rdata_o    (w_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            wen_q           <= 1'b0;
            size_q          <= 2'b00;
            unsigned_q      <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= 32'h0;
            rdata_q         <= 32'h0;
            err_q           <= 1'b0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            rsp_valid_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        wen_q       <= req_wen;
                        size_q      <= req_size;
                        unsigned_q  <= req_unsigned;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        // Bad requests skip memory entirely and report an error.
                        if (req_is_bad(req_size, req_addr[1:0])) begin
                            rdata_q     <= 32'h0;
                            err_q       <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            mem_req_valid_q <= 1'b1;
                            state_q         <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        cnt_q           <= '0;
                        state_q         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // A response in the expiry cycle takes priority over the timeout.
                    if (mem_rsp_valid) begin
                        rdata_q     <= wen_q ? 32'h0 : w_load;
                        err_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q     <= 32'h0;
                        err_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_wen       = wen_q;
    assign mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata     = w_wdata;
    assign mem_wmask     = wen_q ? w_mask : 4'b0000;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
// ============================================================================
//  Module   : tb_lsu_mem_initiator
//  Summary  : Directed self-checking bench for lsu_mem_initiator (TIMEOUT = 4).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_mem_initiator;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    int n_vec;
    int n_err;

    lsu_mem_initiator #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wen       (req_wen),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wen, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_wen      = wen;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        tick();
        req_valid    = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        rsp_ready = 1'b1; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
        tick();
        tick();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
        chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b0;
        tick();

        // lb at 0x80000003: sign-extended top byte of the word
        issue(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0);
        chk("lb_mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("lb_mem_addr", mem_addr, 32'h8000_0000);
        chk("lb_mem_wmask", {28'd0, mem_wmask}, 32'd0);
        chk("lb_req_ready_busy", {31'd0, req_ready}, 32'd0);
        chk("lb_rsp_valid_c1", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("lb_rsp_valid_c2", {31'd0, rsp_valid}, 32'd0);
        mem_rsp_valid = 1'b1; mem_rdata = 32'h80FF_1234;
        tick();
        mem_rsp_valid = 1'b0;
        chk("lb_rsp_valid_c3", {31'd0, rsp_valid}, 32'd1);
        chk("lb_rdata", rsp_rdata, 32'hFFFF_FF80);
        chk("lb_err", {31'd0, rsp_err}, 32'd0);
        tick();
        chk("lb_back_idle", {31'd0, req_ready}, 32'd1);
        chk("lb_rsp_drop", {31'd0, rsp_valid}, 32'd0);

        // sh at 0x80000002: upper-half lanes, replicated data
        issue(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'hDEAD_BEEF);
        chk("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
        chk("sh_mem_wmask", {28'd0, mem_wmask}, 32'h0000_000C);
        chk("sh_mem_wen", {31'd0, mem_wen}, 32'd1);
        chk("sh_mem_addr", mem_addr, 32'h8000_0000);
        tick();
        mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_rsp_valid = 1'b0;
        chk("sh_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("sh_rdata", rsp_rdata, 32'h0);
        chk("sh_err", {31'd0, rsp_err}, 32'd0);
        tick();

        // sb at offset 1 and lbu at offset 1
        issue(1'b1, 2'd0, 1'b0, 32'h8000_0101, 32'h0000_00A5);
        chk("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk("sb_mem_wmask", {28'd0, mem_wmask}, 32'h0000_0002);
        tick();
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        tick();
        issue(1'b0, 2'd0, 1'b1, 32'h8000_0101, 32'h0);
        tick();
        mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_F100;
        tick();
        mem_rsp_valid = 1'b0;
        chk("lbu_rdata", rsp_rdata, 32'h0000_00F1);
        tick();

        // Misaligned lw: error response next cycle, no memory access
        issue(1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'h0);
        chk("mis_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("mis_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("mis_rsp_err", {31'd0, rsp_err}, 32'd1);
        chk("mis_rdata", rsp_rdata, 32'h0);
        tick();
        // Illegal size 3
        issue(1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0);
        chk("sz3_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("sz3_rsp_err", {31'd0, rsp_err}, 32'd1);
        tick();

        // Backpressure on both sides
        mem_req_ready = 1'b0; rsp_ready = 1'b0;
        issue(1'b1, 2'd2, 1'b0, 32'h8000_0010, 32'h1357_9BDF);
        for (int i = 0; i < 5; i++) begin
            chk("bp_mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("bp_mem_addr", mem_addr, 32'h8000_0010);
            chk("bp_mem_wdata", mem_wdata, 32'h1357_9BDF);
            chk("bp_mem_wmask", {28'd0, mem_wmask}, 32'h0000_000F);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        chk("bp_req_dropped", {31'd0, mem_req_valid}, 32'd0);
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h0);
            chk("bp_rsp_err", {31'd0, rsp_err}, 32'd0);
            chk("bp_req_ready_resp", {31'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_done", {31'd0, req_ready}, 32'd1);

        // Timeout: four WAIT cycles with no response
        rsp_ready = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0);
        tick();
        tick(); tick(); tick();
        chk("to_still_wait", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
        chk("to_rdata", rsp_rdata, 32'h0);
        rsp_ready = 1'b1;
        tick();

        // Response arrives in the expiry cycle: data wins
        issue(1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0);
        tick();
        tick(); tick(); tick();
        chk("tx_still_wait", {31'd0, rsp_valid}, 32'd0);
        mem_rsp_valid = 1'b1; mem_rdata = 32'h1122_3344;
        tick();
        mem_rsp_valid = 1'b0;
        chk("tx_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("tx_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("tx_rdata", rsp_rdata, 32'h1122_3344);
        tick();

        // Asynchronous reset in WAIT, then a stale response
        issue(1'b0, 2'd2, 1'b0, 32'h8000_0040, 32'h0);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("ar_req_ready", {31'd0, req_ready}, 32'd1);
        chk("ar_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("ar_mem_addr", mem_addr, 32'h0);
        tick();
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rsp_valid = 1'b0;
        chk("ar_stale_rsp", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("ar_stale_rsp2", {31'd0, rsp_valid}, 32'd0);
        issue(1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0);
        tick();
        mem_rsp_valid = 1'b1; mem_rdata = 32'h8001_5555;
        tick();
        mem_rsp_valid = 1'b0;
        chk("lhu_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("lhu_rdata", rsp_rdata, 32'h0000_8001);
        chk("lhu_err", {31'd0, rsp_err}, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
